// File: rtl/gpr_wb_if.sv
// Writeback bus between the ALU/LSU result sources, the arbiter and the register file.
// Signal names keep the arbiter's _i/_o direction suffixes.
interface gpr_wb_if #(
  parameter int DATA_LEN = 64,
  parameter int RF_SIZE  = 5
);
  logic                alu_valid_i;
  logic [RF_SIZE-1:0]  alu_rd_i;
  logic [DATA_LEN-1:0] alu_data_i;
  logic                alu_ready_o;
  logic                lsu_valid_i;
  logic [RF_SIZE-1:0]  lsu_rd_i;
  logic [DATA_LEN-1:0] lsu_data_i;
  logic                lsu_ready_o;
  logic                gpr_we_o;
  logic [RF_SIZE-1:0]  gpr_rd_o;
  logic [DATA_LEN-1:0] gpr_data_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  alu_ready_o, lsu_ready_o,
    input  gpr_we_o, gpr_rd_o, gpr_data_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output alu_ready_o, lsu_ready_o,
    output gpr_we_o, gpr_rd_o, gpr_data_o
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Two-source (ALU/LSU) register-file writeback arbiter with a registered write stage.
// Optional pending-write hazard scoreboard is compiled in with GPR_WB_SCOREBOARD_EN.
module gpr_wb_arbiter #(
  parameter int DATA_LEN = 64,
  parameter int RF_SIZE  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  gpr_wb_if.slave            wb,
  input  logic               issue_valid_i,
  input  logic [RF_SIZE-1:0] issue_rd_i,
  input  logic [RF_SIZE-1:0] chk_rs1_i,
  input  logic [RF_SIZE-1:0] chk_rs2_i,
  output logic               hazard_o
);
  // Handshake: a source transfers in the cycle where its valid_i and ready_o
  // are both high; ready_o is combinational and never high without valid_i.
  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_LSU = 1'b1;

  logic                alu_req, lsu_req;
  logic                grant_alu, grant_lsu, hs;
  logic [RF_SIZE-1:0]  sel_rd;
  logic [DATA_LEN-1:0] sel_data;

  logic [0:0]          last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [RF_SIZE-1:0]  rd_q, rd_d;
  logic [DATA_LEN-1:0] data_q, data_d;

  // Requests are masked in reset so nothing can be accepted while it is held.
  assign alu_req   = rst_n & wb.alu_valid_i;
  assign lsu_req   = rst_n & wb.lsu_valid_i;
  assign grant_alu = alu_req & (~lsu_req | (last_grant_q == GRANT_LSU));
  assign grant_lsu = lsu_req & ~grant_alu;
  assign hs        = grant_alu | grant_lsu;
  assign sel_rd    = grant_alu ? wb.alu_rd_i   : wb.lsu_rd_i;
  assign sel_data  = grant_alu ? wb.alu_data_i : wb.lsu_data_i;

  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;
    if (hs) begin
      last_grant_d = grant_lsu ? GRANT_LSU : GRANT_ALU;
      we_d         = (sel_rd != '0);
      rd_d         = sel_rd;
      data_d       = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_LSU;
      we_q         <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign wb.alu_ready_o = grant_alu;
  assign wb.lsu_ready_o = grant_lsu;
  assign wb.gpr_we_o    = we_q;
  assign wb.gpr_rd_o    = rd_q;
  assign wb.gpr_data_o  = data_q;

`ifdef GPR_WB_SCOREBOARD_EN
  logic [(2**RF_SIZE)-1:0] pending_q, pending_d;

  // Set is applied after clear so a same-cycle reissue keeps the bit (newer producer).
  always_comb begin
    pending_d = pending_q;
    if (hs && (sel_rd != '0))
      pending_d[sel_rd] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0))
      pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hazard_o = pending_q[chk_rs1_i] | pending_q[chk_rs2_i];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid_i, issue_rd_i, chk_rs1_i, chk_rs2_i};
  assign hazard_o = 1'b0;
`endif
endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_LEN, default 64, meaning register data width.
REQ-002 SHALL have parameter RF_SIZE, default 5, meaning register index width (2**RF_SIZE registers).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  ALU writeback request.
REQ-006 SHALL have port alu_rd_i  input  RF_SIZE  ALU destination index.
REQ-007 SHALL have port alu_data_i  input  DATA_LEN  ALU result.
REQ-008 SHALL have port alu_ready_o  output  1  ALU request granted this cycle.
REQ-009 SHALL have port lsu_valid_i  input  1  load-unit writeback request.
REQ-010 SHALL have port lsu_rd_i  input  RF_SIZE  load destination index.
REQ-011 SHALL have port lsu_data_i  input  DATA_LEN  load result.
REQ-012 SHALL have port lsu_ready_o  output  1  load request granted this cycle.
REQ-013 SHALL have port gpr_we_o  output  1  register-file write enable.
REQ-014 SHALL have port gpr_rd_o  output  RF_SIZE  register-file write index.
REQ-015 SHALL have port gpr_data_o  output  DATA_LEN  register-file write data.
REQ-016 SHALL have port issue_valid_i  input  1  instruction issued that will write issue_rd_i.
REQ-017 SHALL have port issue_rd_i  input  RF_SIZE  destination of issued instruction.
REQ-018 SHALL have ports chk_rs1_i, chk_rs2_i  input  RF_SIZE each  source indices to check.
REQ-019 SHALL have port hazard_o  output  1  a checked source has a pending write.

Function
REQ-020 Handshake SHALL occur on a source when valid_i and ready_o are both high in the same cycle; ready_o is combinational from valid inputs and arbitration state.
REQ-021 Only one source SHALL receive ready_o in any cycle; ready_o SHALL never be high while its valid_i is low.
REQ-022 Single requester SHALL be granted immediately.
REQ-023 Both requesting SHALL grant the source opposite to last_grant (1-bit register, updated on every handshake to the granted source).
REQ-024 Granted request SHALL appear on gpr_we_o/gpr_rd_o/gpr_data_o exactly one cycle after handshake (registered output stage); gpr_we_o SHALL be low in cycles after no handshake.
REQ-025 Handshake with rd == 0 SHALL be accepted but SHALL produce gpr_we_o = 0 next cycle.
REQ-026 Scoreboard: pending vector of 2**RF_SIZE bits; issue_valid_i with issue_rd_i != 0 SHALL set pending[issue_rd_i] at next edge.
REQ-027 Writeback handshake with rd != 0 SHALL clear pending[rd] at next edge.
REQ-028 Simultaneous set and clear of same index SHALL leave bit set (newer producer wins).
REQ-029 hazard_o SHALL be combinational: pending[chk_rs1_i] OR pending[chk_rs2_i]; index 0 SHALL never report hazard.
REQ-030 pending[0] SHALL remain 0 permanently.

Reset
REQ-031 While rst_n low at a clock edge: gpr_we_o=0, gpr_rd_o=0, gpr_data_o=0, last_grant=LSU, pending all 0.
REQ-032 During reset, alu_ready_o and lsu_ready_o SHALL be 0; handshakes in flight SHALL be discarded (no write after reset release).
REQ-033 First contention after reset SHALL grant ALU.

Configuration
REQ-034 Macro GPR_WB_SCOREBOARD_EN defined: pending vector and hazard_o logic per REQ-026..030 compiled in.
REQ-035 Macro undefined: no pending storage; hazard_o tied 0; issue and chk inputs ignored; arbitration unchanged.

Verification
REQ-036 ALU only: alu_valid=1, rd=3, data=0x11 -> alu_ready=1 same cycle; next cycle gpr_we=1, rd=3, data=0x11.
REQ-037 Contention 4 cycles after reset, ALU rd=1, LSU rd=2 held valid -> grants ALU,LSU,ALU,LSU; writes rd 1,2,1,2 each one cycle later.
REQ-038 rd=0: lsu_valid=1, rd=0, data=0xFF -> lsu_ready=1; next cycle gpr_we=0.
REQ-039 Scoreboard (macro on): issue rd=5; next cycle chk_rs1=5 -> hazard=1; ALU writeback rd=5 handshake -> hazard=0 following cycle; same-cycle issue rd=5 and writeback rd=5 -> hazard stays 1.
REQ-040 Reset mid-operation: ALU handshake then rst_n=0 next edge -> gpr_we=0, pending all 0, hazard=0; after release contention grants ALU.
REQ-041 Macro off: issue rd=7, chk_rs1=7 -> hazard=0 every cycle.
